// File: rtl/stack_unit.sv
// stack_unit: single-cycle LIFO with PUSH/POP/REDUCE, registered pop data and sticky error flags
module stack_unit #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       pop_valid,
  output logic                       err_overflow,
  output logic                       err_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP = 2'b10;
  localparam logic [1:0] OP_REDUCE = 2'b11;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0] cnt_q, cnt_d, cm1, cm2;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic pop_valid_q, pop_valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic ge2;
  assign cm1 = cnt_q - (AW+1)'(1);
  assign cm2 = cnt_q - (AW+1)'(2);
  assign ge2 = cnt_q >= (AW+1)'(2);
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign tos = empty ? '0 : mem_q[cm1[AW-1:0]];
  assign nos = ge2 ? mem_q[cm2[AW-1:0]] : '0;
  assign pop_data = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign err_overflow = ovf_q;
  assign err_underflow = unf_q;
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    pop_data_d = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (op_valid && op == OP_PUSH) begin
      if (full) ovf_d = 1'b1;
      else begin
        mem_d[cnt_q[AW-1:0]] = push_data;
        cnt_d = cnt_q + (AW+1)'(1);
      end
    end
    if (op_valid && op == OP_POP) begin
      if (empty) unf_d = 1'b1;
      else begin
        cnt_d = cm1;
        pop_data_d = tos;
        pop_valid_d = 1'b1;
      end
    end
    if (op_valid && op == OP_REDUCE) begin
      if (!ge2) unf_d = 1'b1;
      else begin
        mem_d[cm2[AW-1:0]] = push_data;
        cnt_d = cm1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
      pop_data_q <= '0;
      pop_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      pop_data_q <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
endmodule
